// File: rtl/issue_dispatch_queue.sv
// rtl/issue_dispatch_queue.sv - in-order rename-to-issue-slot dispatch buffer with wakeup snoop and branch kill
// Optional same-cycle bypass of an enqueue into a free slot when empty: `define DQ_BYPASS_EN
module issue_dispatch_queue #(
    parameter int DEPTH     = 4,
    parameter int NUM_SLOTS = 8,
    parameter int UOP_W     = 42,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enq_valid,
    output logic                 enq_ready,
    input  logic [UOP_W-1:0]     enq_uop,
    input  logic                 wakeup_0_valid,
    input  logic [6:0]           wakeup_0_pdst,
    input  logic                 wakeup_1_valid,
    input  logic [6:0]           wakeup_1_pdst,
    input  logic [NUM_SLOTS-1:0] slot_valid,
    input  logic                 flush,
    input  logic                 brkill_valid,
    input  logic [11:0]          brkill_mask,
    output logic                 dis_valid,
    output logic [NUM_SLOTS-1:0] dis_sel,
    output logic [UOP_W-1:0]     dis_uop,
    output logic [1:0]           dis_iw_state,
    output logic [CNT_W-1:0]     count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [UOP_W-1:0] uop_q [DEPTH];
    logic [DEPTH-1:0] live_q;
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;

    logic [UOP_W-1:0]     head_uop;
    logic                 head_live, head_hit, enq_hit, any_free;
    logic                 buf_dis, bypass, pop, enq_fire;
    logic [NUM_SLOTS-1:0] free_sel;
    logic                 found;

    // Clear a source busy bit when either wakeup port names that source register.
    function automatic logic [UOP_W-1:0] wake(input logic [UOP_W-1:0] u,
                                              input logic w0v, input logic [6:0] w0p,
                                              input logic w1v, input logic [6:0] w1p);
        logic [UOP_W-1:0] r;
        r = u;
        if ((w0v && w0p == u[15:9]) || (w1v && w1p == u[15:9])) r[1] = 1'b0;
        if ((w0v && w0p == u[8:2])  || (w1v && w1p == u[8:2]))  r[0] = 1'b0;
        return r;
    endfunction

    assign head_uop  = uop_q[head_q];
    assign head_live = live_q[head_q];
    assign head_hit  = brkill_valid && |(head_uop[34:23] & brkill_mask);
    assign enq_hit   = brkill_valid && |(enq_uop[34:23] & brkill_mask);
    assign any_free  = |(~slot_valid);
    assign enq_ready = (count_q != CNT_W'(DEPTH));

    always_comb begin
        free_sel = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!slot_valid[i] && !found) begin
                free_sel[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    // An empty buffer has no live head, so buf_dis is naturally 0 when count is 0.
    assign buf_dis = head_live && any_free && !flush && !head_hit;
`ifdef DQ_BYPASS_EN
    assign bypass = (count_q == '0) && enq_valid && !flush && !enq_hit && any_free;
`else
    assign bypass = 1'b0;
`endif

    assign dis_valid    = buf_dis || bypass;
    assign dis_sel      = dis_valid ? free_sel : '0;
    assign dis_uop      = bypass ? wake(enq_uop, wakeup_0_valid, wakeup_0_pdst, wakeup_1_valid, wakeup_1_pdst)
                                 : wake(head_uop, wakeup_0_valid, wakeup_0_pdst, wakeup_1_valid, wakeup_1_pdst);
    assign dis_iw_state = dis_valid ? 2'b01 : 2'b00;
    assign count        = count_q;

    assign pop      = (count_q != '0) && (buf_dis || !head_live) && !flush;
    assign enq_fire = enq_valid && enq_ready && !flush && !bypass;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            live_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                uop_q[i]  <= wake(uop_q[i], wakeup_0_valid, wakeup_0_pdst, wakeup_1_valid, wakeup_1_pdst);
                live_q[i] <= live_q[i] && !(brkill_valid && |(uop_q[i][34:23] & brkill_mask));
            end
            if (pop) begin
                live_q[head_q] <= 1'b0;
                head_q         <= head_q + PTR_W'(1);
            end
            // Tail never aliases a popping head: pop needs count>0 and enqueue needs count<DEPTH.
            if (enq_fire) begin
                uop_q[tail_q]  <= wake(enq_uop, wakeup_0_valid, wakeup_0_pdst, wakeup_1_valid, wakeup_1_pdst);
                live_q[tail_q] <= !enq_hit;
                tail_q         <= tail_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(enq_fire) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_issue_dispatch_queue.sv
// tb/tb_issue_dispatch_queue.sv - directed plus randomized check of issue_dispatch_queue against a queue-level model
module tb_issue_dispatch_queue;
    localparam int DEPTH = 4;
    localparam int NS    = 8;
    localparam int UW    = 42;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          enq_valid;
    logic          enq_ready;
    logic [UW-1:0] enq_uop;
    logic          wakeup_0_valid, wakeup_1_valid;
    logic [6:0]    wakeup_0_pdst, wakeup_1_pdst;
    logic [NS-1:0] slot_valid;
    logic          flush, brkill_valid;
    logic [11:0]   brkill_mask;
    logic          dis_valid;
    logic [NS-1:0] dis_sel;
    logic [UW-1:0] dis_uop;
    logic [1:0]    dis_iw_state;
    logic [CW-1:0] count;

    issue_dispatch_queue #(.DEPTH(DEPTH), .NUM_SLOTS(NS), .UOP_W(UW)) dut (
        .clk(clk), .reset(reset), .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_uop(enq_uop),
        .wakeup_0_valid(wakeup_0_valid), .wakeup_0_pdst(wakeup_0_pdst),
        .wakeup_1_valid(wakeup_1_valid), .wakeup_1_pdst(wakeup_1_pdst),
        .slot_valid(slot_valid), .flush(flush), .brkill_valid(brkill_valid), .brkill_mask(brkill_mask),
        .dis_valid(dis_valid), .dis_sel(dis_sel), .dis_uop(dis_uop), .dis_iw_state(dis_iw_state),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [UW-1:0] uop;
        bit            live;
    } ent_t;
    ent_t q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [UW-1:0] mk_uop(input logic [11:0] br, input logic [6:0] p1,
                                             input logic [6:0] p2, input logic b1, input logic b0);
        return {7'($urandom), br, 7'($urandom), p1, p2, b1, b0};
    endfunction

    function automatic logic [UW-1:0] twake(input logic [UW-1:0] u);
        logic [UW-1:0] r;
        logic [6:0]    s1, s2;
        r  = u;
        s1 = u[15:9];
        s2 = u[8:2];
        if (wakeup_0_valid && wakeup_0_pdst == s1) r[1] = 1'b0;
        if (wakeup_1_valid && wakeup_1_pdst == s1) r[1] = 1'b0;
        if (wakeup_0_valid && wakeup_0_pdst == s2) r[0] = 1'b0;
        if (wakeup_1_valid && wakeup_1_pdst == s2) r[0] = 1'b0;
        return r;
    endfunction

    function automatic bit killed(input logic [UW-1:0] u);
        return brkill_valid && ((u[34:23] & brkill_mask) != 12'h000);
    endfunction

    // Compare outputs to the model for the current inputs, then advance the model one clock.
    task automatic step();
        bit            exp_dis, byp, exp_ready, any_free, accept;
        logic [NS-1:0] exp_sel;
        logic [UW-1:0] exp_uop;
        ent_t          e;
        #1;
        exp_ready = (q.size() != DEPTH);
        any_free  = (slot_valid != '1);
        exp_dis   = 1'b0;
        byp       = 1'b0;
        exp_uop   = '0;
        if (q.size() > 0 && q[0].live && any_free && !flush && !killed(q[0].uop)) begin
            exp_dis = 1'b1;
            exp_uop = twake(q[0].uop);
        end
`ifdef DQ_BYPASS_EN
        if (q.size() == 0 && enq_valid && !flush && !killed(enq_uop) && any_free) begin
            byp     = 1'b1;
            exp_dis = 1'b1;
            exp_uop = twake(enq_uop);
        end
`endif
        exp_sel = '0;
        if (exp_dis)
            for (int i = NS - 1; i >= 0; i--)
                if (!slot_valid[i]) exp_sel = NS'(1) << i;

        chk("enq_ready", 64'(enq_ready), 64'(exp_ready));
        chk("count", 64'(count), 64'(q.size()));
        chk("dis_valid", 64'(dis_valid), 64'(exp_dis));
        chk("dis_sel", 64'(dis_sel), 64'(exp_sel));
        chk("dis_iw_state", 64'(dis_iw_state), exp_dis ? 64'd1 : 64'd0);
        if (exp_dis) chk("dis_uop", 64'(dis_uop), 64'(exp_uop));

        accept = enq_valid && exp_ready && !flush && !byp;
        if (flush) begin
            q.delete();
        end else begin
            if (q.size() > 0 && (exp_dis || !q[0].live)) void'(q.pop_front());
            foreach (q[i]) begin
                if (killed(q[i].uop)) q[i].live = 1'b0;
                q[i].uop = twake(q[i].uop);
            end
            if (accept) begin
                e.uop  = twake(enq_uop);
                e.live = !killed(enq_uop);
                q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        enq_valid      = 1'b0;
        enq_uop        = '0;
        wakeup_0_valid = 1'b0;
        wakeup_0_pdst  = '0;
        wakeup_1_valid = 1'b0;
        wakeup_1_pdst  = '0;
        slot_valid     = '1;
        flush          = 1'b0;
        brkill_valid   = 1'b0;
        brkill_mask    = '0;
    endtask

    logic [UW-1:0] first_uop;

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_dis_valid", 64'(dis_valid), 64'd0);
        chk("rst_dis_sel", 64'(dis_sel), 64'd0);
        reset = 1'b0;

        // Fill with all slots busy, then open slot 3.
        for (int i = 0; i < DEPTH; i++) begin
            enq_valid = 1'b1;
            enq_uop   = mk_uop(12'h000, 7'(20 + i), 7'(30 + i), 1'b0, 1'b0);
            if (i == 0) first_uop = enq_uop;
            step();
        end
        enq_valid = 1'b0;
        #1;
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(enq_ready), 64'd0);
        chk("full_dis_valid", 64'(dis_valid), 64'd0);
        slot_valid = 8'hF7;
        #1;
        chk("f7_dis_sel", 64'(dis_sel), 64'h08);
        chk("f7_oldest", 64'(dis_uop), 64'(first_uop));
        step();

        // Flush with a same-cycle enqueue drops everything.
        enq_valid  = 1'b1;
        enq_uop    = mk_uop(12'h000, 7'd1, 7'd2, 1'b0, 1'b0);
        slot_valid = '1;
        step();
        flush = 1'b1;
        #1;
        chk("flush_dis_valid", 64'(dis_valid), 64'd0);
        step();
        idle();
        #1;
        chk("post_flush_count", 64'(count), 64'd0);
        chk("post_flush_ready", 64'(enq_ready), 64'd1);

        // Wakeup on a buffered entry and again on the dispatch cycle.
        enq_valid = 1'b1;
        enq_uop   = mk_uop(12'h000, 7'd12, 7'd13, 1'b1, 1'b1);
        step();
        enq_valid      = 1'b0;
        wakeup_1_valid = 1'b1;
        wakeup_1_pdst  = 7'd12;
        step();
        wakeup_1_valid = 1'b0;
        wakeup_0_valid = 1'b1;
        wakeup_0_pdst  = 7'd13;
        slot_valid     = 8'h00;
        #1;
        chk("wake_busy_bits", 64'(dis_uop[1:0]), 64'd0);
        step();
        idle();

        // Kill of 1st and 3rd of three buffered entries.
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1'b1;
            enq_uop   = mk_uop((i == 1) ? 12'h002 : 12'h001, 7'd40, 7'd41, 1'b0, 1'b0);
            step();
        end
        enq_valid    = 1'b0;
        brkill_valid = 1'b1;
        brkill_mask  = 12'h001;
        step();
        idle();
        slot_valid = 8'h00;
        repeat (4) step();

        // Back-to-back enqueue/dispatch with one free slot.
        slot_valid = 8'hFE;
        for (int i = 0; i < 10; i++) begin
            enq_valid = 1'b1;
            enq_uop   = mk_uop(12'h000, 7'(i), 7'(i + 1), 1'b0, 1'b0);
            step();
        end
        idle();
        repeat (2) step();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            enq_valid      = ($urandom_range(0, 9) < 7);
            enq_uop        = mk_uop(($urandom_range(0, 5) < 4) ? (12'h001 << $urandom_range(0, 3)) : 12'h000,
                                    7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)),
                                    1'($urandom), 1'($urandom));
            wakeup_0_valid = ($urandom_range(0, 9) < 3);
            wakeup_0_pdst  = 7'($urandom_range(0, 7));
            wakeup_1_valid = ($urandom_range(0, 9) < 3);
            wakeup_1_pdst  = 7'($urandom_range(0, 7));
            slot_valid     = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            brkill_valid   = ($urandom_range(0, 9) == 0);
            brkill_mask    = 12'h001 << $urandom_range(0, 3);
            flush          = ($urandom_range(0, 31) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
